// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : decode_stage_if
// Brief   : Fetch / register-file / writeback / execute signals of the decode stage.
// Revision: 1.0
// ============================================================================
interface decode_stage_if;
   logic        flush;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        rf_rd_en1;
   logic        rf_rd_en2;
   logic [4:0]  rf_rd_addr1;
   logic [4:0]  rf_rd_addr2;
   logic [31:0] rf_rd_data1;
   logic [31:0] rf_rd_data2;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_val;
   logic [31:0] ex_rs2_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_rd_we;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5;
   logic        ex_illegal;

   // Decode side
   modport slave (
      input  flush, if_valid, if_instr, if_pc, rf_rd_data1, rf_rd_data2,
             wb_en, wb_addr, wb_data, ex_ready,
      output if_ready, rf_rd_en1, rf_rd_en2, rf_rd_addr1, rf_rd_addr2,
             ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we,
             ex_opcode, ex_funct3, ex_funct7b5, ex_illegal
   );

   // Surrounding pipeline side
   modport master (
      output flush, if_valid, if_instr, if_pc, rf_rd_data1, rf_rd_data2,
             wb_en, wb_addr, wb_data, ex_ready,
      input  if_ready, rf_rd_en1, rf_rd_en2, rf_rd_addr1, rf_rd_addr2,
             ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we,
             ex_opcode, ex_funct3, ex_funct7b5, ex_illegal
   );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : decode_stage
// Brief   : RV32I decode / operand fetch with x0 masking and writeback bypass.
// Revision: 1.0
// ============================================================================
module decode_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          reset,
   decode_stage_if.slave bus
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic uses_rs1(input logic [6:0] op);
      return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
   endfunction

   // x0 first, then the live writeback, then last cycle's writeback, then the file.
   function automatic logic [31:0] resolve(
      input logic        used,
      input logic [4:0]  rs,
      input logic [31:0] rf_data,
      input logic        wb_en,
      input logic [4:0]  wb_addr,
      input logic [31:0] wb_data,
      input logic        wbr_vld,
      input logic [4:0]  wbr_addr,
      input logic [31:0] wbr_data
   );
      if (!used || (rs == 5'd0))
         return 32'd0;
      else if (wb_en && (wb_addr == rs))
         return wb_data;
      else if (wbr_vld && (wbr_addr == rs))
         return wbr_data;
      else
         return rf_data;
   endfunction

   state_t      state_q,    state_d;
   logic [31:0] instr_q,    instr_d;
   logic [31:0] pc_q,       pc_d;
   logic        wb_vld_q,   wb_vld_d;
   logic [4:0]  wb_addr_q,  wb_addr_d;
   logic [31:0] wb_data_q,  wb_data_d;
   logic [4:0]  hold_rs1_q, hold_rs1_d;
   logic [4:0]  hold_rs2_q, hold_rs2_d;
   logic        ex_valid_q, ex_valid_d;
   logic [31:0] ex_pc_q,    ex_pc_d;
   logic [31:0] rs1_val_q,  rs1_val_d;
   logic [31:0] rs2_val_q,  rs2_val_d;
   logic [31:0] imm_q,      imm_d;
   logic [4:0]  rd_q,       rd_d;
   logic        rd_we_q,    rd_we_d;
   logic [6:0]  opcode_q,   opcode_d;
   logic [2:0]  funct3_q,   funct3_d;
   logic        f7b5_q,     f7b5_d;
   logic        illegal_q,  illegal_d;

   logic        if_ready;
   logic        accept;
   logic        rd_en1;
   logic        rd_en2;

   logic [6:0]  dec_op;
   logic        dec_use1;
   logic        dec_use2;
   logic        dec_illegal;
   logic        dec_rd_we;
   logic [31:0] dec_imm;

   // Fetch handshake and register-file read port, live only in the accept cycle
   always_comb begin
      if_ready = !reset && !bus.flush &&
                 ((state_q == IDLE) || ((state_q == HOLD) && bus.ex_ready));
      accept   = if_ready && bus.if_valid;
      rd_en1   = accept && uses_rs1(bus.if_instr[6:0]);
      rd_en2   = accept && uses_rs2(bus.if_instr[6:0]);
   end

   assign bus.if_ready    = if_ready;
   assign bus.rf_rd_en1   = rd_en1;
   assign bus.rf_rd_en2   = rd_en2;
   assign bus.rf_rd_addr1 = rd_en1 ? bus.if_instr[19:15] : 5'd0;
   assign bus.rf_rd_addr2 = rd_en2 ? bus.if_instr[24:20] : 5'd0;

   // Field decode of the latched instruction
   always_comb begin
      dec_op      = instr_q[6:0];
      dec_use1    = uses_rs1(dec_op);
      dec_use2    = uses_rs2(dec_op);
      dec_illegal = 1'b0;
      dec_rd_we   = 1'b0;
      dec_imm     = 32'd0;
      case (dec_op)
         OP_LUI, OP_AUIPC: begin
            dec_imm   = {instr_q[31:12], 12'd0};
            dec_rd_we = 1'b1;
         end
         OP_JAL: begin
            dec_imm   = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
            dec_rd_we = 1'b1;
         end
         OP_JALR, OP_LOAD, OP_IMM: begin
            dec_imm   = {{20{instr_q[31]}}, instr_q[31:20]};
            dec_rd_we = 1'b1;
         end
         OP_BRANCH: dec_imm = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
         OP_STORE:  dec_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
         OP_OP:     dec_rd_we = 1'b1;
         OP_MISC, OP_SYSTEM: dec_rd_we = 1'b0;
         default:   dec_illegal = 1'b1;
      endcase
      if (instr_q[1:0] != 2'b11)
         dec_illegal = 1'b1;
      if (dec_illegal || (instr_q[11:7] == 5'd0))
         dec_rd_we = 1'b0;
   end

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      wb_vld_d   = bus.wb_en;
      wb_addr_d  = bus.wb_addr;
      wb_data_d  = bus.wb_data;
      hold_rs1_d = hold_rs1_q;
      hold_rs2_d = hold_rs2_q;
      ex_valid_d = ex_valid_q;
      ex_pc_d    = ex_pc_q;
      rs1_val_d  = rs1_val_q;
      rs2_val_d  = rs2_val_q;
      imm_d      = imm_q;
      rd_d       = rd_q;
      rd_we_d    = rd_we_q;
      opcode_d   = opcode_q;
      funct3_d   = funct3_q;
      f7b5_d     = f7b5_q;
      illegal_d  = illegal_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               instr_d = bus.if_instr;
               pc_d    = bus.if_pc;
               state_d = READ;
            end
         end
         READ: begin
            ex_valid_d = 1'b1;
            ex_pc_d    = pc_q;
            rs1_val_d  = resolve(dec_use1, instr_q[19:15], bus.rf_rd_data1,
                                 bus.wb_en, bus.wb_addr, bus.wb_data,
                                 wb_vld_q, wb_addr_q, wb_data_q);
            rs2_val_d  = resolve(dec_use2, instr_q[24:20], bus.rf_rd_data2,
                                 bus.wb_en, bus.wb_addr, bus.wb_data,
                                 wb_vld_q, wb_addr_q, wb_data_q);
            // An unused operand holds index 0 so a stalled writeback never matches it
            hold_rs1_d = dec_use1 ? instr_q[19:15] : 5'd0;
            hold_rs2_d = dec_use2 ? instr_q[24:20] : 5'd0;
            imm_d      = dec_imm;
            rd_d       = instr_q[11:7];
            rd_we_d    = dec_rd_we;
            opcode_d   = dec_op;
            funct3_d   = instr_q[14:12];
            f7b5_d     = instr_q[30];
            illegal_d  = dec_illegal;
            state_d    = HOLD;
         end
         HOLD: begin
            if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
               if (bus.wb_addr == hold_rs1_q) rs1_val_d = bus.wb_data;
               if (bus.wb_addr == hold_rs2_q) rs2_val_d = bus.wb_data;
            end
            if (bus.ex_ready) begin
               ex_valid_d = 1'b0;
               if (accept) begin
                  instr_d = bus.if_instr;
                  pc_d    = bus.if_pc;
                  state_d = READ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.flush) begin
         state_d    = IDLE;
         ex_valid_d = 1'b0;
         instr_d    = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         instr_q    <= NOP_INSTR;
         pc_q       <= 32'd0;
         wb_vld_q   <= 1'b0;
         wb_addr_q  <= 5'd0;
         wb_data_q  <= 32'd0;
         hold_rs1_q <= 5'd0;
         hold_rs2_q <= 5'd0;
         ex_valid_q <= 1'b0;
         ex_pc_q    <= 32'd0;
         rs1_val_q  <= 32'd0;
         rs2_val_q  <= 32'd0;
         imm_q      <= 32'd0;
         rd_q       <= 5'd0;
         rd_we_q    <= 1'b0;
         opcode_q   <= 7'd0;
         funct3_q   <= 3'd0;
         f7b5_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         wb_vld_q   <= wb_vld_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         hold_rs1_q <= hold_rs1_d;
         hold_rs2_q <= hold_rs2_d;
         ex_valid_q <= ex_valid_d;
         ex_pc_q    <= ex_pc_d;
         rs1_val_q  <= rs1_val_d;
         rs2_val_q  <= rs2_val_d;
         imm_q      <= imm_d;
         rd_q       <= rd_d;
         rd_we_q    <= rd_we_d;
         opcode_q   <= opcode_d;
         funct3_q   <= funct3_d;
         f7b5_q     <= f7b5_d;
         illegal_q  <= illegal_d;
      end
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_pc       = ex_pc_q;
   assign bus.ex_rs1_val  = rs1_val_q;
   assign bus.ex_rs2_val  = rs2_val_q;
   assign bus.ex_imm      = imm_q;
   assign bus.ex_rd       = rd_q;
   assign bus.ex_rd_we    = rd_we_q;
   assign bus.ex_opcode   = opcode_q;
   assign bus.ex_funct3   = funct3_q;
   assign bus.ex_funct7b5 = f7b5_q;
   assign bus.ex_illegal  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// Bench for decode_stage: synchronous register-file model, queue scoreboard
// on the execute handshake, plus direct checks of timing, stalls and flush.
module tb_decode_stage;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rd_we;
      logic        ill;
      logic [31:0] instr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   decode_stage_if bus();

   decode_stage #(.NOP_INSTR(NOP_INSTR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Register file: one-cycle synchronous read, old data on a coincident write
   logic [31:0] regs [32];
   logic [31:0] rf_q1;
   logic [31:0] rf_q2;
   always @(posedge clk) begin
      if (bus.rf_rd_en1) rf_q1 <= regs[bus.rf_rd_addr1];
      if (bus.rf_rd_en2) rf_q2 <= regs[bus.rf_rd_addr2];
      if (bus.wb_en) regs[bus.wb_addr] <= bus.wb_data;
   end
   assign bus.rf_rd_data1 = rf_q1;
   assign bus.rf_rd_data2 = rf_q2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int last_acc = 0;
   exp_t sb_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [4:0] rd,
                               input logic rd_we, input logic ill);
      exp_t e;
      e.instr = instr; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2;
      e.imm = imm; e.rd = rd; e.rd_we = rd_we; e.ill = ill;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.ex_valid && bus.ex_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_out", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_pc",      bus.ex_pc,       e.pc);
            chk("sb_rs1",     bus.ex_rs1_val,  e.rs1);
            chk("sb_rs2",     bus.ex_rs2_val,  e.rs2);
            chk("sb_imm",     bus.ex_imm,      e.imm);
            chk("sb_rd",      bus.ex_rd,       e.rd);
            chk("sb_rd_we",   bus.ex_rd_we,    e.rd_we);
            chk("sb_illegal", bus.ex_illegal,  e.ill);
            chk("sb_opcode",  bus.ex_opcode,   e.instr[6:0]);
            chk("sb_funct3",  bus.ex_funct3,   e.instr[14:12]);
            chk("sb_f7b5",    bus.ex_funct7b5, e.instr[30]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
      step();
      bus.wb_en = 1'b0;
   endtask

   // Offer one instruction until accepted (bounded); checks read-port use in the accept cycle.
   task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                        input logic en1, input logic en2,
                        input exp_t e, input logic push);
      int n;
      n = 0;
      bus.if_valid = 1'b1; bus.if_instr = instr; bus.if_pc = pc;
      if (push) sb_q.push_back(e);
      @(negedge clk);
      while (!bus.if_ready && n < 20) begin
         step();
         @(negedge clk);
         n++;
      end
      chk("accept_ready", bus.if_ready, 1'b1);
      chk("rd_en1", bus.rf_rd_en1, en1);
      chk("rd_en2", bus.rf_rd_en2, en2);
      if (en1) chk("rd_addr1", bus.rf_rd_addr1, instr[19:15]);
      if (en2) chk("rd_addr2", bus.rf_rd_addr2, instr[24:20]);
      step();
      last_acc = cyc;
      bus.if_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int t1;
      reset = 1'b1;
      bus.flush = 1'b0; bus.if_valid = 1'b0; bus.if_instr = 32'd0; bus.if_pc = 32'd0;
      bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0; bus.ex_ready = 1'b1;
      step();
      @(negedge clk);
      chk("rst_if_ready", bus.if_ready, 1'b0);
      chk("rst_ex_valid", bus.ex_valid, 1'b0);
      chk("rst_ex_pc",    bus.ex_pc,    32'd0);
      chk("rst_ex_imm",   bus.ex_imm,   32'd0);
      chk("rst_rd_we",    bus.ex_rd_we, 1'b0);
      chk("rst_rd_en1",   bus.rf_rd_en1, 1'b0);
      step();
      reset = 1'b0;

      // File contents: x0 poisoned, x3 = 10, x8 = 0x11
      wb_write(5'd0, 32'hDEAD_BEEF);
      wb_write(5'd3, 32'd10);
      wb_write(5'd8, 32'h11);
      step();

      // addi x5,x0,7 and its two-cycle latency
      issue(32'h0070_0293, 32'h100, 1'b1, 1'b0,
            mk(32'h0070_0293, 32'h100, 32'd0, 32'd0, 32'd7, 5'd5, 1'b1, 1'b0), 1'b1);
      @(negedge clk);
      chk("lat_n1_valid", bus.ex_valid, 1'b0);
      step();
      @(negedge clk);
      chk("lat_n2_valid", bus.ex_valid, 1'b1);
      repeat (3) step();

      // add x4,x3,x3: writes x3=99 at accept, x3=123 in the read cycle
      bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'd99;
      issue(32'h0031_8233, 32'h104, 1'b1, 1'b1,
            mk(32'h0031_8233, 32'h104, 32'd123, 32'd123, 32'd0, 5'd4, 1'b1, 1'b0), 1'b1);
      bus.wb_data = 32'd123;
      step();
      bus.wb_en = 1'b0;
      repeat (3) step();

      // Same instruction, only the accept-cycle write x3=77
      bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'd77;
      issue(32'h0031_8233, 32'h108, 1'b1, 1'b1,
            mk(32'h0031_8233, 32'h108, 32'd77, 32'd77, 32'd0, 5'd4, 1'b1, 1'b0), 1'b1);
      bus.wb_en = 1'b0;
      repeat (3) step();

      // add x1,x0,x0 with x0 poisoned in the file
      issue(32'h0000_00B3, 32'h10C, 1'b1, 1'b1,
            mk(32'h0000_00B3, 32'h10C, 32'd0, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0), 1'b1);
      repeat (3) step();

      // Stall: add x6,x3,x8, x8 rewritten to 0x55 while held
      bus.ex_ready = 1'b0;
      issue(32'h0081_8333, 32'h110, 1'b1, 1'b1,
            mk(32'h0081_8333, 32'h110, 32'd77, 32'h55, 32'd0, 5'd6, 1'b1, 1'b0), 1'b1);
      step();
      @(negedge clk);
      chk("stall_valid",    bus.ex_valid,   1'b1);
      chk("stall_if_ready", bus.if_ready,   1'b0);
      chk("stall_rs2_pre",  bus.ex_rs2_val, 32'h11);
      step();
      bus.wb_en = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'h55;
      @(negedge clk);
      chk("stall_rs2_mid",  bus.ex_rs2_val, 32'h11);
      step();
      bus.wb_en = 1'b0;
      @(negedge clk);
      chk("stall_rs2_post", bus.ex_rs2_val, 32'h55);
      chk("stall_rs1",      bus.ex_rs1_val, 32'd77);
      chk("stall_pc",       bus.ex_pc,      32'h110);
      chk("stall_rd",       bus.ex_rd,      5'd6);
      chk("stall_valid2",   bus.ex_valid,   1'b1);
      chk("stall_if_rdy2",  bus.if_ready,   1'b0);
      step();
      bus.ex_ready = 1'b1;
      repeat (3) step();

      // addi x7,x8,-1 reads the file directly
      issue(32'hFFF4_0393, 32'h114, 1'b1, 1'b0,
            mk(32'hFFF4_0393, 32'h114, 32'h55, 32'd0, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0), 1'b1);
      repeat (3) step();

      // beq x0,x0,-4
      issue(32'hFE00_0EE3, 32'h118, 1'b1, 1'b1,
            mk(32'hFE00_0EE3, 32'h118, 32'd0, 32'd0, 32'hFFFF_FFFC, 5'h1D, 1'b0, 1'b0), 1'b1);
      repeat (3) step();

      // All-zero word is illegal
      issue(32'h0000_0000, 32'h11C, 1'b1, 1'b0,
            mk(32'h0000_0000, 32'h11C, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1), 1'b1);
      repeat (3) step();

      // sw x0,-8(x0)
      issue(32'hFE00_2C23, 32'h120, 1'b1, 1'b1,
            mk(32'hFE00_2C23, 32'h120, 32'd0, 32'd0, 32'hFFFF_FFF8, 5'h18, 1'b0, 1'b0), 1'b1);
      repeat (3) step();

      // Back-to-back lui x2,0x12345 then jal x1,+8
      issue(32'h1234_5137, 32'h124, 1'b0, 1'b0,
            mk(32'h1234_5137, 32'h124, 32'd0, 32'd0, 32'h1234_5000, 5'd2, 1'b1, 1'b0), 1'b1);
      t1 = last_acc;
      issue(32'h0080_00EF, 32'h128, 1'b0, 1'b0,
            mk(32'h0080_00EF, 32'h128, 32'd0, 32'd0, 32'd8, 5'd1, 1'b1, 1'b0), 1'b1);
      chk("b2b_gap", last_acc - t1, 32'd2);
      repeat (4) step();

      // Flush in the read cycle
      issue(32'h0070_0293, 32'h12C, 1'b1, 1'b0,
            mk(32'h0070_0293, 32'h12C, 32'd0, 32'd0, 32'd7, 5'd5, 1'b1, 1'b0), 1'b0);
      bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_rd_if_ready", bus.if_ready, 1'b0);
      step();
      bus.flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_rd_ex_valid", bus.ex_valid, 1'b0);
         step();
      end

      // Flush with an offer in IDLE
      bus.if_valid = 1'b1; bus.if_instr = 32'h0070_0293; bus.if_pc = 32'h130;
      bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_idle_if_ready", bus.if_ready,  1'b0);
      chk("flush_idle_rd_en1",   bus.rf_rd_en1, 1'b0);
      chk("flush_idle_rd_en2",   bus.rf_rd_en2, 1'b0);
      step();
      bus.if_valid = 1'b0; bus.flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_idle_ex_valid", bus.ex_valid, 1'b0);
         step();
      end

      // Resumes normally after the flushes
      issue(32'h0070_0293, 32'h134, 1'b1, 1'b0,
            mk(32'h0070_0293, 32'h134, 32'd0, 32'd0, 32'd7, 5'd5, 1'b1, 1'b0), 1'b1);
      repeat (4) step();

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
